fixed_to_float_pipe: RTL and testbench
======================================

// Module: fixed_to_float_pipe
// PURPOSE
//   Converts the signed fixed-point result of the CORDIC datapath into an IEEE-754 single.
//   Three-stage pipeline: abs/sign, leading-one detect, normalise/round/pack.
//   Sits directly downstream of the multi-stage CORDIC block.
//   Feeds float_out to the custom-instruction result mux.
//   Valid/ready handshake on both sides, so downstream stalls back-pressure the CORDIC.
// PARAMETERS
//   FIXED_W    22  width of fixed_in, two's complement; legal range 2..32
//   FRAC_BITS  20  fractional bits of fixed_in; value = fixed_in / 2^FRAC_BITS; 0..FIXED_W-1
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active-low
//   in_valid   in   1        fixed_in holds a sample
//   in_ready   out  1        block accepts a sample this cycle
//   fixed_in   in   FIXED_W  signed fixed-point input
//   out_valid  out  1        float_out holds a result
//   out_ready  in   1        consumer takes the result this cycle
//   float_out  out  32       IEEE-754 single {sign, exp[7:0], man[22:0]}
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - v1/v2/v3 stage-valid flags clear; float_out=0; out_valid=0.
//   - in_ready=1 from the first cycle after release.
// - Transfer occurs on a rising clk edge when valid&ready are both high on that side.
// - Stage advance:
//   - adv3 = ~v3 | out_ready; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2.
//   - in_ready = adv1 (combinational, no path from in_valid).
//   - A stage loads when its advance is high; it keeps its data and valid otherwise.
//   - Bubbles collapse.
// - Latency: 3 cycles accept-to-out_valid with out_ready=1; throughput 1 per cycle.
// - out_valid low while out_ready low: no effect.
// - out_valid high while out_ready low: float_out and out_valid hold stable.
// - S1 (sign/abs):
//   - s = fixed_in[FIXED_W-1]; m = s ? -fixed_in : fixed_in, as FIXED_W-bit unsigned.
//   - Most-negative input gives m = 2^(FIXED_W-1), represented exactly.
// - S2 (leading one): p = index of the highest set bit of m; z = (m==0).
// - S3 (pack):
//   - exp = 127 + p - FRAC_BITS (always normal within the legal parameter range).
//   - man = the p bits below the leading one, left-aligned to 23 bits.
//   - When p > 23, the low p-23 bits are dropped and rounded per CONFIGURATION.
//   - Rounding carry out of the mantissa increments exp and clears man.
//   - z=1 gives float_out = 32'h0000_0000; negative zero is never produced.
// - Reset mid-operation: all in-flight samples are discarded; no partial result is emitted.
// - Simultaneous accept and emit in the same cycle with a full pipe is legal; no sample is lost or duplicated.
// CONFIGURATION
//   F2F_ROUND_NEAREST_EN defined:
//   - Dropped bits use round-to-nearest, ties-to-even: guard, round and sticky bits from the discarded field.
//   F2F_ROUND_NEAREST_EN undefined:
//   - Dropped bits are truncated (round toward zero); rounding logic is not built.
//   No effect when FIXED_W <= 24 (p <= 23, exact conversion).
// TESTING
//   - Defaults, reset released, out_ready=1:
//     - fixed_in=22'h100000 -> float_out=32'h3F80_0000, 3 cycles after accept.
//     - 22'h0C0000 -> 32'h3F40_0000.
//     - 22'h300000 -> 32'hBF80_0000.
//     - 22'h200000 -> 32'hC000_0000.
//     - 22'h000000 -> 32'h0000_0000.
//   - Stream 8 back-to-back samples, out_ready=1: 8 results in order, one per cycle; in_ready stays 1.
//   - Hold out_ready=0 for 6 cycles while driving in_valid=1:
//     - Exactly 3 samples accepted, then in_ready=0.
//     - float_out stable throughout.
//     - Release out_ready: results drain in order with no loss or duplication.
//   - FIXED_W=32, FRAC_BITS=0, fixed_in=32'h0100_0003:
//     - F2F_ROUND_NEAREST_EN defined -> 32'h4B80_0002.
//     - Undefined -> 32'h4B80_0001.
//   - FIXED_W=32, FRAC_BITS=0, fixed_in=32'h01FF_FFFF with F2F_ROUND_NEAREST_EN -> 32'h4C00_0000 (mantissa carry).
//   - Assert rst_n=0 with 3 samples in flight:
//     - out_valid=0 and float_out=0 immediately.
//     - After release, no stale result appears; the first new sample emerges after 3 cycles.

Source files
------------

// File: rtl/fixed_to_float_pipe.sv
// -----------------------------------------------------------------------------
// fixed_to_float_pipe
//   Converts a signed two's-complement fixed-point sample from the CORDIC
//   datapath into an IEEE-754 single-precision value. The conversion runs in
//   three pipeline stages:
//     S1  sign capture and absolute value
//     S2  leading-one detect
//     S3  normalise, optional round, pack
//   Both sides use a valid/ready handshake. Each stage holds while the stage
//   after it is full and stalled, so bubbles collapse and back-pressure from
//   the result mux propagates straight to the CORDIC.
//
// Configuration macro:
//   F2F_ROUND_NEAREST_EN  defined   -> discarded mantissa bits are rounded
//                                      to nearest, ties to even
//                         undefined -> discarded bits are truncated
//   Rounding only matters when FIXED_W > 24; narrower inputs convert exactly.
//
// Parameters:
//   FIXED_W    width of fixed_in (2..32)
//   FRAC_BITS  fractional bits of fixed_in (0..FIXED_W-1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   fixed_in holds a sample
//   in_ready   block accepts a sample this cycle
//   fixed_in   signed fixed-point input, value = fixed_in / 2^FRAC_BITS
//   out_valid  float_out holds a result
//   out_ready  consumer takes the result this cycle
//   float_out  IEEE-754 single {sign, exp[7:0], man[22:0]}
// -----------------------------------------------------------------------------
module fixed_to_float_pipe #(
    parameter int FIXED_W   = 22,
    parameter int FRAC_BITS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIXED_W-1:0] fixed_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        float_out
);

    // -------------------------------------------------------------------------
    // Stage registers
    // -------------------------------------------------------------------------
    logic               v1_q, v2_q, v3_q;
    logic               s1_q, s2_q;
    logic [FIXED_W-1:0] m1_q, m2_q;
    logic [4:0]         p2_q;          // FIXED_W <= 32, so 5 bits cover any index
    logic               z2_q;
    logic [31:0]        float_q;

    // Next-state data
    logic               s1_d;
    logic [FIXED_W-1:0] m1_d;
    logic [4:0]         p2_d;
    logic               z2_d;
    logic [31:0]        float_d;

    // -------------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its contents move on
    // this cycle. in_ready depends only on state and out_ready.
    // -------------------------------------------------------------------------
    logic adv1, adv2, adv3;

    assign adv3     = ~v3_q | out_ready;
    assign adv2     = ~v2_q | adv3;
    assign adv1     = ~v1_q | adv2;
    assign in_ready = adv1;

    assign out_valid = v3_q;
    assign float_out = float_q;

    // -------------------------------------------------------------------------
    // S1: sign and magnitude. The magnitude is held unsigned at FIXED_W bits,
    // so the most-negative input maps to 2^(FIXED_W-1) without overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        s1_d = fixed_in[FIXED_W-1];
        m1_d = s1_d ? (~fixed_in + FIXED_W'(1)) : fixed_in;
    end

    // -------------------------------------------------------------------------
    // S2: leading-one position. Ascending scan so the last hit is the MSB.
    // -------------------------------------------------------------------------
    always_comb begin
        p2_d = '0;
        for (int i = 0; i < FIXED_W; i++) begin
            if (m1_q[i]) p2_d = 5'(i);
        end
        z2_d = (m1_q == '0);
    end

    // -------------------------------------------------------------------------
    // S3: normalise so the leading one lands on bit 63 of a 64-bit word.
    // Bits [62:40] are the stored mantissa; anything below bit 40 is only
    // non-zero when p > 23 and is the discarded field.
    // -------------------------------------------------------------------------
    logic [63:0] ext;
    logic [22:0] man_t;
    logic [22:0] man_f;
    logic        carry;
    logic [9:0]  exp_w;
    logic        unused_ok;

    always_comb begin
        ext   = 64'(m2_q) << (6'd63 - {1'b0, p2_q});
        man_t = ext[62:40];
    end

`ifdef F2F_ROUND_NEAREST_EN
    logic        g_bit, r_bit, st_bit, rnd_up;
    logic [23:0] man_sum;

    // Round to nearest, ties to even: round up when above half, or exactly
    // half with an odd LSB. An all-ones mantissa overflows into bit 23,
    // leaving the lower bits zero and bumping the exponent.
    always_comb begin
        g_bit   = ext[39];
        r_bit   = ext[38];
        st_bit  = |ext[37:0];
        rnd_up  = g_bit & (r_bit | st_bit | man_t[0]);
        man_sum = {1'b0, man_t} + {23'd0, rnd_up};
        carry   = man_sum[23];
        man_f   = man_sum[22:0];
    end

    assign unused_ok = ^{ext[63], exp_w[9:8]};
`else
    always_comb begin
        carry = 1'b0;
        man_f = man_t;
    end

    // Hidden bit and discarded field are not needed when truncating.
    assign unused_ok = ^{ext[63], ext[39:0], exp_w[9:8]};
`endif

    always_comb begin
        exp_w   = 10'd127 + {5'd0, p2_q} - 10'(FRAC_BITS) + {9'd0, carry};
        float_d = {s2_q, exp_w[7:0], man_f};
        // Zero input: positive zero regardless of any other field.
        if (z2_q) float_d = 32'h0000_0000;
    end

    // -------------------------------------------------------------------------
    // Pipeline registers. Valid follows the advance signal; data is only
    // captured when the upstream stage actually holds a sample, so float_out
    // keeps the last result while bubbles pass through.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            s1_q    <= 1'b0;
            m1_q    <= '0;
            s2_q    <= 1'b0;
            m2_q    <= '0;
            p2_q    <= '0;
            z2_q    <= 1'b0;
            float_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                    m1_q <= m1_d;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_q <= s1_q;
                    m2_q <= m1_q;
                    p2_q <= p2_d;
                    z2_q <= z2_d;
                end
            end
            if (adv3) begin
                v3_q <= v2_q;
                if (v2_q) float_q <= float_d;
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_float_pipe
//   Self-checking bench. dut drives the default 22/20 format through a
//   scoreboard; dut32 uses FIXED_W=32, FRAC_BITS=0 for the rounding cases.
// -----------------------------------------------------------------------------
module tb_fixed_to_float_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] fixed_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] float_out;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] fixed_in2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] float_out2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_lat = 1'b0;

    typedef struct {
        logic [31:0] val;
        int          acc;
    } exp_t;
    exp_t sb[$];

`ifdef F2F_ROUND_NEAREST_EN
    localparam logic [31:0] E_RND   = 32'h4B80_0002;
    localparam logic [31:0] E_HI    = 32'h4B80_0004;
    localparam logic [31:0] E_STK   = 32'h4C80_0001;
    localparam logic [31:0] E_CARRY = 32'h4C00_0000;
`else
    localparam logic [31:0] E_RND   = 32'h4B80_0001;
    localparam logic [31:0] E_HI    = 32'h4B80_0003;
    localparam logic [31:0] E_STK   = 32'h4C80_0000;
    localparam logic [31:0] E_CARRY = 32'h4BFF_FFFF;
`endif

    fixed_to_float_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fixed_in  (fixed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .float_out (float_out)
    );

    fixed_to_float_pipe #(.FIXED_W(32), .FRAC_BITS(0)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .fixed_in  (fixed_in2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .float_out (float_out2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference via the simulator's double: every 22-bit value is exact in
    // both double and single, so rebiasing the exponent and cutting the
    // mantissa gives the single-precision encoding.
    function automatic logic [31:0] model(input logic [21:0] v);
        int          iv;
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        iv = $signed(v);
        if (iv == 0) return 32'h0;
        r = $itor(iv) / 1048576.0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out: got %h with empty scoreboard, expected no output", float_out);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", float_out, e.val);
                if (chk_lat) check("latency", 32'(cyc + 1 - e.acc), 32'd3);
            end
        end
    end

    // Present one sample, wait (bounded) for acceptance, push its expectation.
    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input logic [21:0] v, input logic [31:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        fixed_in = v;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        if (in_ready) sb.push_back('{e, cyc + 1});
        @(posedge clk); #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] v, input logic [31:0] e);
        int n;
        n = 0;
        in_valid2 = 1'b1;
        fixed_in2 = v;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready2), 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid2) break;
            n++;
            if (n > 10) break;
        end
        check({tag, "_valid"}, 32'(out_valid2), 32'd1);
        check(tag, float_out2, e);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int          t0;
        int          acc;
        bit          have_hold;
        bit          took;
        logic [31:0] hold;
        logic [21:0] v;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_float_out", float_out, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ---- directed conversions with latency
        chk_lat = 1'b1;
        send(22'h100000, 32'h3F80_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h0C0000, 32'h3F40_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h300000, 32'hBF80_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h200000, 32'hC000_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h000000, 32'h0000_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h000001, 32'h3580_0000); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        send(22'h1FFFFF, 32'h3FFF_FFF8); in_valid = 1'b0; repeat (5) @(posedge clk); #1;
        check("directed_drained", 32'(sb.size()), 32'd0);

        // ---- 8 back-to-back samples
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            check("stream_in_ready", 32'(in_ready), 32'd1);
            v = (i == 3) ? 22'h200000 : 22'($urandom);
            send(v, model(v));
        end
        in_valid = 1'b0;
        check("stream_cycles", 32'(cyc - t0), 32'd8);
        drain(20);

        // ---- stall with out_ready low for 6 cycles
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        fixed_in  = 22'($urandom);
        acc       = 0;
        have_hold = 1'b0;
        hold      = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            took = in_ready;
            if (took) begin
                sb.push_back('{model(fixed_in), cyc + 1});
                acc++;
            end
            if (out_valid) begin
                if (!have_hold) begin
                    hold      = float_out;
                    have_hold = 1'b1;
                end else begin
                    check("stall_stable", float_out, hold);
                end
            end
            @(posedge clk); #1;
            if (took) fixed_in = 22'($urandom);
        end
        check("stall_accepts", 32'(acc), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // ---- reset with three samples in flight
        send(22'h0C0000, 32'h3F40_0000);
        send(22'h300000, 32'hBF80_0000);
        send(22'h100000, 32'h3F80_0000);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_float_out", float_out, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk_lat = 1'b1;
        send(22'h100000, 32'h3F80_0000);
        in_valid = 1'b0;
        drain(10);

        // ---- 32-bit integer format: rounding boundaries
        send32("w32_rnd",     32'h0100_0003, E_RND);
        send32("w32_tie",     32'h0100_0001, 32'h4B80_0000);
        send32("w32_above",   32'h0100_0007, E_HI);
        send32("w32_sticky",  32'h0400_0005, E_STK);
        send32("w32_carry",   32'h01FF_FFFF, E_CARRY);
        send32("w32_neg1",    32'hFFFF_FFFF, 32'hBF80_0000);
        send32("w32_mostneg", 32'h8000_0000, 32'hCF00_0000);
        send32("w32_zero",    32'h0000_0000, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
